// File: rtl/mem_stage_pkg.sv
// Shared pipeline bundle types for the ex->mem->wb path.
// ctrl_t carries valid/mem_rd/mem_wr/func3; reg_t is a register addr/value pair.
package mem_stage_pkg;

  localparam int RegWidth = 32;

  typedef struct packed {
    logic       valid;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] func3;
  } ctrl_t;

  typedef struct packed {
    logic [4:0]          addr;
    logic [RegWidth-1:0] value;
  } reg_t;

  typedef struct packed {
    ctrl_t ctrl;
    reg_t  rs;
    reg_t  rd;
  } ex_mem_t;

  typedef struct packed {
    ctrl_t ctrl;
    reg_t  rd;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage.sv
// Memory stage: iEX in, oWB/oFwMe out, req/ack data bus (oMem*/iMem*),
// oStall holds execute during an access, oFault flags bad or timed-out ops.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                 iClk,
  input  logic                 nRst,
  input  ex_mem_t              iEX,
  output mem_wb_t              oWB,
  output logic [RegWidth-1:0]  oFwMe,
  output logic                 oStall,
  output logic                 oFault,
  output logic                 oMemReq,
  output logic                 oMemWe,
  output logic [AddrWidth-1:0] oMemAddr,
  output logic [3:0]           oMemBe,
  output logic [RegWidth-1:0]  oMemWData,
  input  logic                 iMemAck,
  input  logic [RegWidth-1:0]  iMemRData
);

  localparam int CntW =
    (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast =
    CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam bit WdEn = (TimeoutCycles > 0);

  typedef enum logic {IDLE, REQ} state_t;

  state_t r_state;
  state_t w_next;

  mem_wb_t              r_wb;
  logic                 r_fault;
  logic                 r_req;
  logic                 r_we;
  logic [AddrWidth-1:0] r_addr;
  logic [3:0]           r_be;
  logic [RegWidth-1:0]  r_wdata;
  logic [CntW-1:0]      r_cnt;
  ctrl_t                r_ctrl;
  logic [4:0]           r_rda;
  logic [1:0]           r_off;

  logic                 w_op;
  logic                 w_ill;
  logic                 w_mis;
  logic                 w_go;
  logic                 w_bad;
  logic                 w_stall;
  logic                 w_to;
  logic [1:0]           w_off;
  logic [2:0]           w_f3;
  logic [3:0]           w_be;
  logic [RegWidth-1:0]  w_wdata;
  logic [AddrWidth-1:0] w_addr;
  logic [RegWidth-1:0]  w_lane;
  logic [RegWidth-1:0]  w_ext;
  logic [RegWidth-1:0]  w_rdv;
  logic                 w_unused;

  assign w_off  = iEX.rd.value[1:0];
  assign w_f3   = iEX.ctrl.func3;
  assign w_addr = {iEX.rd.value[AddrWidth-1:2], 2'b00};
  assign w_unused = ^iEX.rs.addr;

  assign w_op = iEX.ctrl.valid
              & (iEX.ctrl.mem_rd | iEX.ctrl.mem_wr);

  // stores only allow 0xx, loads reject x11 and 110
  assign w_ill = (iEX.ctrl.mem_rd & iEX.ctrl.mem_wr)
               | (iEX.ctrl.mem_wr & w_f3[2])
               | (w_f3[1:0] == 2'b11)
               | (iEX.ctrl.mem_rd & (w_f3 == 3'b110));

  assign w_mis = ((w_f3[1:0] == 2'b01) & w_off[0])
               | ((w_f3[1:0] == 2'b10) & (w_off != 2'b00));

  assign w_go  = w_op & ~w_ill & ~w_mis;
  assign w_bad = w_op & ~w_go;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = iEX.rs.value;
    unique case (1'b1)
      (w_f3[1:0] == 2'b00): begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{iEX.rs.value[7:0]}};
      end
      (w_f3[1:0] == 2'b01): begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{iEX.rs.value[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_lane = iMemRData >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_lane;
    unique case (r_ctrl.func3)
      3'b000: w_ext = {{(RegWidth-8){w_lane[7]}}, w_lane[7:0]};
      3'b001: w_ext = {{(RegWidth-16){w_lane[15]}}, w_lane[15:0]};
      3'b100: w_ext = {{(RegWidth-8){1'b0}}, w_lane[7:0]};
      3'b101: w_ext = {{(RegWidth-16){1'b0}}, w_lane[15:0]};
      default: ;
    endcase
  end

  assign w_rdv = r_ctrl.mem_rd ? w_ext : '0;

  // ack in the timeout cycle takes priority over the abort
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_to    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_stall = w_go;
        if (w_go) w_next = REQ;
      end
      REQ: begin
        w_to    = WdEn & ~iMemAck & (r_cnt == CntLast);
        w_stall = ~iMemAck & ~w_to;
        if (iMemAck | w_to) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_wb    <= '0;
      r_fault <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_ctrl  <= '0;
      r_rda   <= '0;
      r_off   <= '0;
    end else begin
      r_fault <= 1'b0;
      r_wb    <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_go) begin
            r_req   <= 1'b1;
            r_we    <= iEX.ctrl.mem_wr;
            r_addr  <= w_addr;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            r_ctrl  <= iEX.ctrl;
            r_rda   <= iEX.rd.addr;
            r_off   <= w_off;
          end else if (w_bad) begin
            r_fault <= 1'b1;
          end else if (iEX.ctrl.valid) begin
            r_wb.ctrl <= iEX.ctrl;
            r_wb.rd   <= iEX.rd;
          end
        end
        REQ: begin
          if (iMemAck) begin
            r_req        <= 1'b0;
            r_wb.ctrl    <= r_ctrl;
            r_wb.rd.addr <= r_rda;
            r_wb.rd.value <= w_rdv;
          end else if (w_to) begin
            r_req   <= 1'b0;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign oWB       = r_wb;
  assign oFwMe     = r_wb.rd.value;
  assign oStall    = w_stall;
  assign oFault    = r_fault;
  assign oMemReq   = r_req;
  assign oMemWe    = r_we;
  assign oMemAddr  = r_addr;
  assign oMemBe    = r_be;
  assign oMemWData = r_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expectations, a negedge
// monitor pops them against writeback/fault and bus activity.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  logic        iClk = 1'b0;
  logic        nRst = 1'b0;
  ex_mem_t     iEX;
  mem_wb_t     oWB;
  logic [31:0] oFwMe;
  logic        oStall, oFault, oMemReq, oMemWe;
  logic [31:0] oMemAddr;
  logic [3:0]  oMemBe;
  logic [31:0] oMemWData;
  logic        iMemAck = 1'b0;
  logic [31:0] iMemRData = '0;

  mem_stage #(.AddrWidth(32), .TimeoutCycles(TO)) dut (
    .iClk(iClk), .nRst(nRst), .iEX(iEX), .oWB(oWB), .oFwMe(oFwMe),
    .oStall(oStall), .oFault(oFault), .oMemReq(oMemReq),
    .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemBe(oMemBe),
    .oMemWData(oMemWData), .iMemAck(iMemAck), .iMemRData(iMemRData)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    bit          fault;
    logic [5:0]  ctrl;
    logic [4:0]  rda;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // memory responder: ack after cur_lat request cycles
  int          cur_lat = 1;
  logic [31:0] cur_rdata = '0;
  int          rcyc = 0;
  bit          force_ack = 0;

  always @(posedge iClk) begin
    #1;
    if (oMemReq && nRst) rcyc++;
    else rcyc = 0;
    iMemAck   = force_ack || (oMemReq && rcyc == cur_lat);
    iMemRData = cur_rdata;
  end

  // monitor
  bit   mon_en = 0;
  bit   prev_req = 0;
  bus_t cur_bus;
  exp_t me;

  always @(negedge iClk) begin
    if (mon_en && nRst) begin
      if (oWB.ctrl.valid || oFault) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out act=%h/%b req=none", oWB, oFault);
        end else begin
          me = exp_q.pop_front();
          if (me.fault) begin
            chk("fault_kind", {oFault, oWB.ctrl.valid}, 2'b10);
          end else begin
            chk("wb_kind", {oFault, oWB.ctrl.valid}, 2'b01);
            chk("wb_ctrl", oWB.ctrl, me.ctrl);
            chk("wb_rda", oWB.rd.addr, me.rda);
            chk("wb_val", oWB.rd.value, me.val);
            chk("fwd_val", oFwMe, me.val);
          end
        end
      end
      if (oMemReq) begin
        if (!prev_req) begin
          if (bus_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req act=%h req=none", oMemAddr);
            cur_bus = '{1'b0, 32'h0, 4'h0, 32'h0};
          end else begin
            cur_bus = bus_q.pop_front();
          end
        end
        chk("bus_ctl", {oMemWe, oMemBe, oMemAddr},
            {cur_bus.we, cur_bus.be, cur_bus.addr});
        chk("bus_wd", oMemWe ? oMemWData : 32'h0,
            cur_bus.we ? cur_bus.wd : 32'h0);
      end
    end
    prev_req = oMemReq;
  end

  // reference model + driver; entered and left at posedge+2
  task automatic run_op(bit v, bit rd, bit wr, logic [2:0] f3,
                        logic [31:0] rs, logic [4:0] rda,
                        logic [31:0] rdv, int lat, logic [31:0] word);
    ex_mem_t ex;
    exp_t    e;
    bus_t    b;
    bit      legal;
    int      sz, off, nst, stalls;
    longint  raw;
    nst = 0;
    if (rd && wr)  legal = 0;
    else if (wr)   legal = (f3 <= 3'd2);
    else           legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz  = 1 << (int'(f3) % 4);
    off = int'(rdv % 4);
    ex.ctrl.valid  = v;
    ex.ctrl.mem_rd = rd;
    ex.ctrl.mem_wr = wr;
    ex.ctrl.func3  = f3;
    ex.rs.addr     = 5'($urandom);
    ex.rs.value    = rs;
    ex.rd.addr     = rda;
    ex.rd.value    = rdv;
    e.ctrl = ex.ctrl;
    e.rda  = rda;
    e.val  = 0;
    e.fault = 0;
    if (!v) begin
    end else if (!(rd || wr)) begin
      e.val = rdv;
      exp_q.push_back(e);
    end else if (!legal || (rdv % sz) != 0) begin
      e.fault = 1;
      exp_q.push_back(e);
    end else begin
      b.we   = wr;
      b.addr = rdv - off;
      b.be   = 4'(((1 << sz) - 1) << off);
      if (sz == 1)      b.wd = (rs & 32'hFF) * 32'h01010101;
      else if (sz == 2) b.wd = (rs & 32'hFFFF) * 32'h00010001;
      else              b.wd = rs;
      bus_q.push_back(b);
      if (TO != 0 && lat > TO) begin
        nst = TO;
        e.fault = 1;
      end else begin
        nst = lat;
        if (rd) begin
          raw = longint'(word) >> (8 * off);
          raw = raw % (64'd1 << (8 * sz));
          if (f3 < 4 && sz < 4 && raw >= (64'd1 << (8 * sz - 1)))
            raw = raw - (64'd1 << (8 * sz));
          e.val = 32'(raw);
        end
      end
      exp_q.push_back(e);
    end
    iEX       = ex;
    cur_lat   = lat;
    cur_rdata = word;
    stalls = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge iClk);
      if (!oStall) break;
      stalls++;
    end
    chk("stall_cycles", 64'(stalls), 64'(nst));
    @(posedge iClk);
    #2;
  endtask

  initial begin
    bus_t rb;
    int   k, r;
    iEX = '0;
    #12;
    chk("rst_wb", oWB, 0);
    chk("rst_fault", oFault, 0);
    chk("rst_req", {oMemReq, oMemWe, oMemBe}, 0);
    chk("rst_addr", oMemAddr, 0);
    chk("rst_wdata", oMemWData, 0);
    chk("rst_stall", oStall, 0);
    @(negedge iClk);
    nRst = 1'b1;
    mon_en = 1;
    @(posedge iClk);
    #2;

    run_op(1, 0, 0, 3'd0, 32'h55, 5'd5, 32'h1234, 1, 0);
    run_op(1, 1, 0, 3'd0, 0, 5'd7, 32'h103, 1, 32'h80FF7F01);
    run_op(1, 1, 0, 3'd4, 0, 5'd8, 32'h103, 1, 32'h80FF7F01);
    run_op(1, 0, 1, 3'd1, 32'hAAAABEEF, 5'd9, 32'h202, 3, 0);
    run_op(1, 1, 0, 3'd2, 0, 5'd3, 32'h006, 1, 0);
    run_op(1, 1, 0, 3'd2, 0, 5'd4, 32'h040, 5, 32'h12345678);
    run_op(1, 1, 0, 3'd2, 0, 5'd4, 32'h040, 4, 32'h12345678);
    run_op(1, 1, 0, 3'd5, 0, 5'd6, 32'h012, 2, 32'h8001C0DE);
    run_op(1, 1, 1, 3'd0, 0, 5'd1, 32'h010, 1, 0);
    run_op(1, 0, 1, 3'd4, 0, 5'd1, 32'h010, 1, 0);
    run_op(0, 1, 0, 3'd0, 0, 5'd1, 32'h010, 1, 0);

    // reset in the middle of an outstanding access
    iEX = '0;
    iEX.ctrl.valid  = 1'b1;
    iEX.ctrl.mem_rd = 1'b1;
    iEX.ctrl.func3  = 3'd2;
    iEX.rd.value    = 32'h80;
    rb = '{1'b0, 32'h80, 4'hF, 32'h0};
    bus_q.push_back(rb);
    cur_lat = 100;
    @(posedge iClk);
    #2;
    @(posedge iClk);
    #2;
    nRst = 1'b0;
    #1;
    chk("rst_mid_req", oMemReq, 0);
    chk("rst_mid_wb", oWB, 0);
    iEX = '0;
    @(posedge iClk);
    #2;
    nRst = 1'b1;
    cur_lat = 1;
    force_ack = 1;
    repeat (3) @(posedge iClk);
    #2;
    force_ack = 0;
    chk("late_ack_wb", oWB.ctrl.valid, 0);

    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 99);
      r = $urandom_range(0, 9);
      if (k < 10)
        run_op(0, 1'($urandom), 1'($urandom), 3'($urandom),
               $urandom, 5'($urandom), $urandom, 1, 0);
      else if (k < 35)
        run_op(1, 0, 0, 3'($urandom), $urandom, 5'($urandom),
               $urandom, 1, 0);
      else
        run_op(1, r < 5, r >= 4, 3'($urandom), $urandom,
               5'($urandom), $urandom & 32'hFFFF,
               $urandom_range(1, 5), $urandom);
    end

    iEX = '0;
    repeat (4) @(posedge iClk);
    #2;
    chk("exp_q_drained", 64'(exp_q.size()), 0);
    chk("bus_q_drained", 64'(bus_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory stage, directly downstream of the execute stage.
- Consumes the registered ex_mem_t bundle and drives a single-port data-memory bus with a req/ack handshake for loads and stores.
- Aligns and extends load data, and produces the mem_wb_t bundle for writeback plus the forwarding value used by execute.
- Stalls upstream while a bus access is outstanding; flags misaligned, illegal or timed-out accesses.

Parameters:
- AddrWidth, 32, data-memory byte address width.
- TimeoutCycles, 255, max cycles oMemReq may wait for iMemAck before abort; 0 disables the watchdog.

Ports:
- iClk  in  1  clock; all state updates on rising edge.
- nRst  in  1  reset, asynchronous, active-low.
- iEX  in  ex_mem_t  from execute; uses ctrl.valid, ctrl.mem_rd, ctrl.mem_wr, ctrl.func3, rs.value (store data), rd.addr, rd.value (ALU result / address).
- oWB  out  mem_wb_t  registered to writeback: ctrl, rd.addr, rd.value.
- oFwMe  out  RegWidth  equals oWB.rd.value; forwarding source for execute.
- oStall  out  1  combinational; high = upstream must hold iEX stable.
- oFault  out  1  registered one-cycle pulse on misaligned, illegal func3 or timeout.
- oMemReq  out  1  bus request.
- oMemWe  out  1  1 = store.
- oMemAddr  out  AddrWidth  word-aligned address (rd.value with [1:0] = 0).
- oMemBe  out  4  byte enables.
- oMemWData  out  RegWidth  store data, lane-positioned.
- iMemAck  in  1  access complete; load data valid this cycle.
- iMemRData  in  RegWidth  raw word read data.

Behaviour:
- Reset (async, nRst low): oWB='0, oFault=0, oMemReq=0, oMemWe=0, oMemAddr=0, oMemBe=0, oMemWData=0, FSM=IDLE, timeout counter=0. An outstanding access is dropped; iMemAck is ignored until reset releases.
- Memory op = iEX.ctrl.valid && (mem_rd || mem_wr). If both are set, the op is treated as illegal.
- Non-memory instruction (valid, no mem op): registered into oWB next cycle, 1-cycle latency; rd.value passed through; oStall=0.
- FSM IDLE:
  - Legal, aligned memory op: oStall=1; next state REQ. oMemReq/We/Addr/Be/WData are registered and become visible in the REQ cycle.
  - Misaligned or illegal op: no request, oStall=0; next cycle oFault=1 and oWB is a bubble (ctrl.valid=0).
- FSM REQ:
  - oMemReq=1; all bus outputs held stable until ack.
  - iMemAck may arrive in the first REQ cycle.
  - oStall = !iMemAck.
  - On ack: next state IDLE, oMemReq drops next cycle, and oWB is loaded with the iEX ctrl/rd.addr. For loads, rd.value = extended data; for stores, rd.value = 0.
  - Minimum memory-op latency is 2 cycles (IDLE, then REQ with ack).
- Bubble rule: while oStall=1, oWB.ctrl.valid=0 on every edge.
- Alignment: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0. Byte ops are always aligned.
- Store func3: SB=000, SH=001, SW=010; anything else is illegal.
  - SB: Be=0001<<addr[1:0]; WData = byte replicated in all 4 lanes.
  - SH: Be=0011<<addr[1:0]; WData = half replicated in both halves.
  - SW: Be=1111.
- Load func3: LB=000, LH=001, LW=010, LBU=100, LHU=101; 011/110/111 are illegal.
  - Select lane by addr[1:0].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Load Be follows the same rules as stores.
- Watchdog:
  - Counter clears on entering REQ and increments each REQ cycle without ack.
  - On count==TimeoutCycles (when nonzero): abort to IDLE, oMemReq=0, oFault=1 pulse, oWB bubble, oStall=0.
  - An ack arriving in the same cycle as the timeout wins; no fault is raised.
- iEX is only resampled in IDLE; changes to iEX during REQ are ignored.

Test Plan:
- ADD result rd.value=0x1234, rd.addr=5, no mem → oWB.rd.value=0x1234 and rd.addr=5 one cycle later; oStall never high.
- LB at addr 0x103, mem word 0x80FF7F01, ack in first REQ cycle → oStall high 1 cycle, oMemAddr=0x100, oMemBe=1000, oWB.rd.value=0xFFFFFF80; LBU of the same yields 0x00000080.
- SH addr 0x202, rs.value=0xAAAABEEF, ack after 3 REQ cycles → oMemWe=1, oMemBe=1100, oMemWData=0xBEEFBEEF held stable 3 cycles; oStall high for 3 cycles; 3 bubbles then the store retires with rd.value=0.
- LW addr 0x006 → no oMemReq; oFault pulses once; oWB.ctrl.valid=0; oStall stays 0.
- TimeoutCycles=4, no ack → oMemReq high 4 cycles then low; oFault pulses; pipeline resumes. Repeat with ack on the 4th cycle → no fault, load retires.
- nRst low during REQ → oMemReq and oWB clear immediately; a late iMemAck after reset release causes no writeback.
